// File: rtl/instr_stream_loader.sv
// instr_stream_loader
// -------------------
// Writer side of the instruction path. Accepts {op, arg} field pairs from the
// test/boot host over a valid/ready stream. Each pair is packed into one
// instruction word. The words are written one after another into instruction
// memory through a registered write port.
//
// Handshake: a field pair transfers on a rising edge where in_valid and
// in_ready are both 1. in_ready is 1 only while a load session is open and the
// memory is not yet full. in_ready does not depend on in_valid. The host may
// hold in_valid without limit. The memory write for a transfer appears on the
// cycle after the transfer edge.
//
// Optional feature (macro LOADER_CHECKSUM_EN): adds a checksum output. It is
// the XOR of every word written in the current session.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   start      in   single-cycle pulse; opens a load session (from IDLE/DONE)
//   in_valid   in   host presents a field pair
//   in_ready   out  loader accepts the field pair this cycle
//   in_op      in   opcode field   -> word bits [OPW+ARGW-1:ARGW]
//   in_arg     in   operand field  -> word bits [ARGW-1:0]
//   in_last    in   field pair is the final word of the program
//   mem_we     out  instruction memory write enable
//   mem_addr   out  write address
//   mem_wdata  out  encoded word {op, arg}
//   busy       out  session in progress
//   done       out  session complete; held until the next start
//   full       out  all 2**AW words written this session
//   word_count out  words written this session
//   checksum   out  (LOADER_CHECKSUM_EN only) XOR of the words written

module instr_stream_loader #(
  parameter int            OPW        = 3,
  parameter int            ARGW       = 6,
  parameter int            AW         = 8,
  parameter logic [AW-1:0] START_ADDR = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OPW-1:0]       in_op,
  input  logic [ARGW-1:0]      in_arg,
  input  logic                 in_last,
  output logic                 mem_we,
  output logic [AW-1:0]        mem_addr,
  output logic [OPW+ARGW-1:0]  mem_wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 full,
  output logic [AW:0]          word_count
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [OPW+ARGW-1:0]  checksum
`endif
);

  // word_count value that means every memory location has been written
  localparam logic [AW:0] DEPTH_CNT = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [AW-1:0] ptr;
  logic          accept;
  logic          start_session;
  logic [AW:0]   cnt_inc;
  logic          last_slot;

  assign cnt_inc   = word_count + 1'b1;
  // The word accepted now takes the final free location
  assign last_slot = (cnt_inc == DEPTH_CNT);

  assign busy = (state == S_LOAD);
  assign done = (state == S_DONE);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and handshake
  always_comb begin
    state_next    = state;
    in_ready      = 1'b0;
    accept        = 1'b0;
    start_session = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_next    = S_LOAD;
          start_session = 1'b1;
        end
      end
      S_LOAD: begin
        // start is ignored while a session is open
        in_ready = ~full;
        accept   = in_valid & ~full;
        if (accept && (in_last || last_slot)) begin
          state_next = S_DONE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Write port, pointer and session counters.
  // Reset drops any write that was accepted in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr        <= START_ADDR;
      mem_we     <= 1'b0;
      mem_addr   <= START_ADDR;
      mem_wdata  <= '0;
      word_count <= '0;
      full       <= 1'b0;
    end else begin
      mem_we <= accept;
      if (start_session) begin
        ptr        <= START_ADDR;
        word_count <= '0;
        full       <= 1'b0;
      end else if (accept) begin
        mem_addr   <= ptr;
        mem_wdata  <= {in_op, in_arg};
        ptr        <= ptr + 1'b1;  // wraps modulo 2**AW
        word_count <= cnt_inc;
        full       <= last_slot;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Updates on the accept edge. The new value is visible in the same cycle
  // as the matching mem_we pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      checksum <= '0;
    end else if (start_session) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= checksum ^ {in_op, in_arg};
    end
  end
`endif

endmodule

// File: tb/tb_instr_stream_loader.sv
// Testbench for instr_stream_loader. There are two instances:
//   a: AW=8, START_ADDR=0 (default geometry)
//   b: AW=3, START_ADDR=6 (small memory with a wrapping pointer)
// Both instances receive the same host stimulus. A reference model runs at the
// transaction level. It tracks each instance's session mode, word count and
// checksum. On every accepted field pair it pushes the expected {addr, data}
// write into a queue. A monitor on the falling edge pops an entry whenever the
// DUT pulses mem_we. It also checks the status outputs.

module tb_instr_stream_loader;

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_DONE = 2;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       start    = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_last  = 1'b0;
  logic [2:0] in_op    = '0;
  logic [5:0] in_arg   = '0;

  logic       rdy_a, we_a, busy_a, done_a, full_a;
  logic [7:0] addr_a;
  logic [8:0] wd_a;
  logic [8:0] wc_a;
  logic       rdy_b, we_b, busy_b, done_b, full_b;
  logic [2:0] addr_b;
  logic [8:0] wd_b;
  logic [3:0] wc_b;
  logic [8:0] ck_a, ck_b;

  always #5 clk = ~clk;

  instr_stream_loader #(.OPW(3), .ARGW(6), .AW(8), .START_ADDR(8'd0)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(rdy_a), .in_op(in_op), .in_arg(in_arg), .in_last(in_last),
    .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wd_a), .busy(busy_a),
    .done(done_a), .full(full_a), .word_count(wc_a)
`ifdef LOADER_CHECKSUM_EN
    , .checksum(ck_a)
`endif
  );

  instr_stream_loader #(.OPW(3), .ARGW(6), .AW(3), .START_ADDR(3'd6)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(rdy_b), .in_op(in_op), .in_arg(in_arg), .in_last(in_last),
    .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wd_b), .busy(busy_b),
    .done(done_b), .full(full_b), .word_count(wc_b)
`ifdef LOADER_CHECKSUM_EN
    , .checksum(ck_b)
`endif
  );

`ifndef LOADER_CHECKSUM_EN
  assign ck_a = '0;
  assign ck_b = '0;
`endif

  // ---------------- reference model ----------------
  int   depth[2]     = '{256, 8};
  int   start_adr[2] = '{0, 6};
  int   mode[2]      = '{M_IDLE, M_IDLE};
  int   cnt[2]       = '{0, 0};
  bit   fullm[2]     = '{1'b0, 1'b0};
  bit   exp_we[2]    = '{1'b0, 1'b0};
  int   last_addr[2] = '{0, 6};
  int   last_data[2] = '{0, 0};
  int   ck[2]        = '{0, 0};
  logic [16:0] exp_q0[$];
  logic [16:0] exp_q1[$];

  task automatic model_step(input int i);
    bit acc;
    int a;
    int d;
    logic [16:0] e;
    acc = (mode[i] == M_LOAD) && !fullm[i] && in_valid;
    exp_we[i] = 1'b0;
    if (!rst_n) begin
      mode[i] = M_IDLE; cnt[i] = 0; fullm[i] = 1'b0; ck[i] = 0;
      last_addr[i] = start_adr[i]; last_data[i] = 0;
    end else if (mode[i] != M_LOAD) begin
      if (start) begin
        mode[i] = M_LOAD; cnt[i] = 0; fullm[i] = 1'b0; ck[i] = 0;
      end
    end else if (acc) begin
      a = (start_adr[i] + cnt[i]) % depth[i];
      d = {23'd0, in_op, in_arg};
      e = {a[7:0], d[8:0]};
      if (i == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
      exp_we[i]    = 1'b1;
      last_addr[i] = a;
      last_data[i] = d;
      cnt[i]       = cnt[i] + 1;
      ck[i]        = ck[i] ^ d;
      if (cnt[i] == depth[i]) fullm[i] = 1'b1;
      if (in_last || fullm[i]) mode[i] = M_DONE;
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  // ---------------- scoreboard / monitor ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_inst(input int i, input logic we, input logic [31:0] addr,
                            input logic [31:0] wd, input logic rdy, input logic bsy,
                            input logic dn, input logic fl, input logic [31:0] wc,
                            input logic [31:0] cks);
    string p;
    logic [16:0] e;
    int qn;
    p  = (i == 0) ? "a" : "b";
    qn = (i == 0) ? exp_q0.size() : exp_q1.size();
    chk({p, "_mem_we"}, {31'd0, we}, {31'd0, exp_we[i]});
    if (we === 1'b1) begin
      if (qn == 0) begin
        n_cmp++; n_err++;
        $display("FAIL %s_unexpected_write at %0t: addr %0h data %0h, expected no write",
                 p, $time, addr, wd);
      end else begin
        e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        chk({p, "_wr_addr"}, addr, {24'd0, e[16:9]});
        chk({p, "_wr_data"}, wd, {23'd0, e[8:0]});
      end
    end else if (exp_we[i] && qn > 0) begin
      // missed write already reported above; drop it to stay aligned
      if (i == 0) void'(exp_q0.pop_front());
      else        void'(exp_q1.pop_front());
    end
    chk({p, "_mem_addr"},   addr, last_addr[i]);
    chk({p, "_mem_wdata"},  wd, last_data[i]);
    chk({p, "_in_ready"},   {31'd0, rdy}, {31'd0, (mode[i] == M_LOAD) && !fullm[i]});
    chk({p, "_busy"},       {31'd0, bsy}, {31'd0, mode[i] == M_LOAD});
    chk({p, "_done"},       {31'd0, dn},  {31'd0, mode[i] == M_DONE});
    chk({p, "_full"},       {31'd0, fl},  {31'd0, fullm[i]});
    chk({p, "_word_count"}, wc, cnt[i]);
`ifdef LOADER_CHECKSUM_EN
    chk({p, "_checksum"},   cks, ck[i]);
`else
    if (cks !== 32'd0) chk({p, "_checksum_tie"}, cks, 32'd0);
`endif
  endtask

  always @(negedge clk) begin
    check_inst(0, we_a, {24'd0, addr_a}, {23'd0, wd_a}, rdy_a, busy_a, done_a, full_a,
               {23'd0, wc_a}, {23'd0, ck_a});
    check_inst(1, we_b, {29'd0, addr_b}, {23'd0, wd_b}, rdy_b, busy_b, done_b, full_b,
               {28'd0, wc_b}, {23'd0, ck_b});
  end

  // ---------------- driver ----------------
  task automatic cyc(input logic st, input logic v, input logic [2:0] op,
                     input logic [5:0] arg, input logic lst);
    start = st; in_valid = v; in_op = op; in_arg = arg; in_last = lst;
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_word(input logic lst);
    cyc(1'b0, 1'b1, 3'($urandom_range(0, 7)), 6'($urandom_range(0, 63)), lst);
  endtask

  initial begin
    // Reset
    rst_n = 1'b0;
    cyc(0, 0, 0, 0, 0);
    cyc(1, 1, 3'd7, 6'h3F, 0);  // start during reset is ignored
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0);

    // Reset in the same cycle as a third accept
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 3'd1, 6'h11, 0);
    cyc(0, 1, 3'd2, 6'h22, 0);
    rst_n = 1'b0;
    cyc(0, 1, 3'd3, 6'h33, 0);
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0);

    // Basic load: 9'h085, 9'h0FF, 9'h100 back-to-back
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 3'b010, 6'h05, 0);
    cyc(0, 1, 3'b011, 6'h3F, 0);
    cyc(0, 1, 3'b100, 6'h00, 1);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    // Backpressure: in_valid 1,0,1, then the last word
    cyc(1, 0, 0, 0, 0);
    rnd_word(0);
    cyc(0, 0, 3'd5, 6'h2A, 0);
    rnd_word(0);
    cyc(0, 0, 0, 0, 0);
    rnd_word(1);
    cyc(0, 0, 0, 0, 0);

    // Wrap and full on instance b; instance a stays in LOAD
    cyc(1, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) rnd_word(0);
    rnd_word(0);               // 9th word: refused by b
    rnd_word(1);               // ends a's session
    cyc(0, 0, 0, 0, 0);

    // Ignored inputs: in_valid in IDLE, start during LOAD, restart from DONE
    rst_n = 1'b0;
    cyc(0, 0, 0, 0, 0);
    rst_n = 1'b1;
    rnd_word(0);
    rnd_word(1);
    cyc(1, 0, 0, 0, 0);
    rnd_word(0);
    cyc(1, 1, 3'd6, 6'h15, 0);  // start during LOAD with a word
    cyc(1, 0, 0, 0, 0);
    rnd_word(1);
    rnd_word(0);                // in_valid in DONE
    cyc(1, 0, 0, 0, 0);         // restart
    rnd_word(0);
    rnd_word(1);
    cyc(0, 0, 0, 0, 0);

    // Fill instance a completely (256 words, no last)
    cyc(1, 0, 0, 0, 0);
    for (int k = 0; k < 260; k++) rnd_word(0);
    cyc(0, 0, 0, 0, 0);

    // Random traffic with occasional resets and starts
    for (int k = 0; k < 600; k++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      cyc(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
          3'($urandom_range(0, 7)), 6'($urandom_range(0, 63)),
          ($urandom_range(0, 7) == 0));
    end
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    @(negedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_stream_loader.md
Name: instr_stream_loader

Overview:
- Writer side of the instruction path: packs {op, arg} fields into 9-bit instruction words and writes them sequentially into instruction memory.
- The control decoder later reads these words and decodes the op field.
- Sits between the test/boot host interface (valid/ready stream) and the instruction memory write port.
- Registered write port, load-session state machine, word counter.

Parameters:
- OPW, 3, opcode field width (instruction bits [8:6])
- ARGW, 6, operand field width (instruction bits [5:0]); OPW+ARGW = 9
- AW, 8, instruction memory address width; DEPTH = 2**AW words
- START_ADDR, 0, first address written in every load session

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  single-cycle pulse; opens a load session
- in_valid  in  1  host presents a field pair
- in_ready  out  1  loader accepts field pair this cycle
- in_op  in  OPW  opcode field
- in_arg  in  ARGW  operand field
- in_last  in  1  marks final word of the program
- mem_we  out  1  instruction memory write enable
- mem_addr  out  AW  write address
- mem_wdata  out  9  encoded word {op, arg}
- busy  out  1  session in progress
- done  out  1  session complete; held until next start
- full  out  1  DEPTH words written this session
- word_count  out  AW+1  words written this session

Behaviour:
- Reset (rst_n=0 at edge): state IDLE, mem_we=0, mem_addr=START_ADDR, mem_wdata=0, busy=0, done=0, full=0, word_count=0.
  - A write pending from the previous cycle is dropped; no mem_we pulse follows reset.
- States IDLE, LOAD, DONE.
- IDLE:
  - in_ready=0.
  - start=1 -> LOAD; write pointer = START_ADDR; word_count=0.
- LOAD:
  - busy=1; in_ready = ~full (combinational from registered full).
  - Accept when in_valid && in_ready.
  - On accept, at the next edge: mem_we=1, mem_addr=pointer, mem_wdata={in_op,in_arg}, pointer+1, word_count+1. Write latency is exactly 1 cycle from the accept edge.
  - No accept: mem_we=0 next cycle; mem_addr/mem_wdata hold their last values.
  - Back-to-back accepts give one write per cycle; no bubbles.
  - Pointer wraps modulo 2**AW (START_ADDR=250, AW=8: ..., 255, 0, 1, ...).
  - Capacity is DEPTH words regardless of START_ADDR.
  - full=1 when word_count reaches DEPTH. in_ready drops in the same cycle full rises.
  - Accept with in_last=1 -> DONE at the same edge as its write.
  - Word that makes word_count=DEPTH -> DONE, even if in_last=0.
  - start during LOAD is ignored.
- DONE:
  - busy=0, done=1, in_ready=0; word_count and full hold.
  - start=1 -> LOAD as from IDLE: done=0, full=0, word_count=0, pointer=START_ADDR.
- Simultaneous:
  - start and rst_n=0: reset wins.
  - in_valid without a session: ignored, no write.
- Encoding is a pure field concatenation; no opcode validation. Unused opcodes are written verbatim.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - Adds output checksum [8:0], reset to 0.
  - Cleared on start.
  - XOR-accumulates every written mem_wdata in the same cycle mem_we=1; holds in DONE.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset mid-session: start, accept 2 words, assert rst_n=0 in the same cycle as a third accept -> mem_we never pulses for the third word; next cycle all outputs at reset values.
- Basic load: start, stream (op=3'b010,arg=6'h05), (3'b011,6'h3F), (3'b100,6'h00,last) back-to-back -> writes at addr 0,1,2 with data 9'h085, 9'h0FF, 9'h100 on consecutive cycles; done=1 after the third write; word_count=3.
- Backpressure/idle: in_valid toggled 1,0,1 -> mem_we=1,0,1 one cycle later; mem_addr increments only on writes.
- Wrap and full: AW=3, START_ADDR=6, stream 8 words with no last -> addresses 6,7,0..5; full=1 and in_ready=0 after the 8th accept; DONE; a 9th in_valid is not written.
- Ignored inputs: in_valid in IDLE and start during LOAD -> no writes in IDLE, session continues unchanged; restart from DONE -> addresses begin again at START_ADDR and word_count resets to 0.
- With LOADER_CHECKSUM_EN defined: words 9'h085, 9'h0FF, 9'h100 -> checksum=9'h17A after the last write; a new start clears it to 0.
